// File: rtl/clock_pkg.sv
// Shared clock-domain types: set_state encoding, field widths and limits.
// Used by the time counter, display mux and time-setting controller.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } set_state_t;

  // Wrapping step; out-of-range values snap back into range.
  function automatic logic [5:0] step_val(
    input logic [5:0] v,
    input logic [5:0] vmax,
    input logic       up
  );
    logic [5:0] r;
    if (up)
      r = (v >= vmax) ? 6'd0 : v + 6'd1;
    else if (v == 6'd0)
      r = vmax;
    else if (v > vmax)
      r = vmax;
    else
      r = v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge detect with hold-to-repeat step generation.
// Steps on press, after REPEAT_DELAY ticks held, then every REPEAT_RATE ticks.
module btn_repeat #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_step
);

  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXC + 1);

  logic          r_prev;
  logic          r_rep;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          w_press;
  logic          w_held;
  logic          w_fire;

  assign w_press  = i_btn & ~r_prev;
  assign w_held   = i_btn & r_prev;
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_fire   = w_held & i_tick &
                    (r_rep ? (w_cnt_nx == CW'(REPEAT_RATE))
                           : (w_cnt_nx == CW'(REPEAT_DELAY)));
  assign o_step   = ~i_clr & (w_press | w_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_btn;
      if (i_clr || !i_btn) begin
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (w_fire) begin
        r_rep <= 1'b1;
        r_cnt <= '0;
      end else if (w_held && i_tick) begin
        r_cnt <= w_cnt_nx;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: edit hour then minute, commit
// with a one-cycle load strobe; counting is paused while editing.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int BLINK_TICKS  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic              time_count_en,
  output logic              load_en,
  output logic [HOUR_W-1:0] hour_out,
  output logic [MIN_W-1:0]  min_out,
  output logic [1:0]        set_state,
  output logic              blink_on
);

  localparam int BW = $clog2(BLINK_TICKS + 1);

  set_state_t    r_state;
  logic          r_mode_prev;
  logic [BW-1:0] r_bcnt;

  logic       w_mode_press;
  logic       w_edit;
  logic       w_clr;
  logic       w_inc_step;
  logic       w_dec_step;
  logic       w_step;
  logic [5:0] w_hour_st;
  logic [5:0] w_min_st;

  assign w_mode_press = btn_mode & ~r_mode_prev;
  assign w_edit = (r_state == SET_HOUR) || (r_state == SET_MIN);
  // Mode beats steps; both step buttons at once cancel each other.
  assign w_clr  = ~w_edit | w_mode_press | (btn_inc & btn_dec);
  assign w_step = w_inc_step | w_dec_step;
  assign w_hour_st = step_val(6'(hour_out), 6'(MAX_HOUR), w_inc_step);
  assign w_min_st  = step_val(min_out, 6'(MAX_MIN), w_inc_step);
  assign set_state = r_state;

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_inc),
    .i_tick(tick_en),
    .i_clr (w_clr),
    .o_step(w_inc_step)
  );

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dec (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_dec),
    .i_tick(tick_en),
    .i_clr (w_clr),
    .o_step(w_dec_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_mode_prev   <= 1'b1;
      r_bcnt        <= '0;
      time_count_en <= 1'b1;
      load_en       <= 1'b0;
      hour_out      <= '0;
      min_out       <= '0;
      blink_on      <= 1'b0;
    end else begin
      r_mode_prev <= btn_mode;
      load_en     <= 1'b0;
      unique case (r_state)
        RUN: begin
          time_count_en <= 1'b1;
          blink_on      <= 1'b0;
          r_bcnt        <= '0;
          if (w_mode_press) begin
            r_state       <= SET_HOUR;
            hour_out      <= cur_hour;
            min_out       <= cur_min;
            time_count_en <= 1'b0;
            blink_on      <= 1'b1;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (w_mode_press) begin
            r_bcnt <= '0;
            if (r_state == SET_HOUR) begin
              r_state  <= SET_MIN;
              blink_on <= 1'b1;
            end else begin
              r_state  <= COMMIT;
              load_en  <= 1'b1;
              blink_on <= 1'b0;
            end
          end else begin
            if (w_step) begin
              if (r_state == SET_HOUR)
                hour_out <= w_hour_st[HOUR_W-1:0];
              else
                min_out <= w_min_st;
            end
            if (tick_en) begin
              if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                r_bcnt   <= '0;
                blink_on <= ~blink_on;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          r_state       <= RUN;
          time_count_en <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table, directed corner sequences and
// randomized stimulus against a tick-counting reference model.
module tb_time_set_ctrl;

  localparam int RD = 50;
  localparam int RR = 10;
  localparam int BT = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       time_count_en;
  logic       load_en;
  logic [4:0] hour_out;
  logic [5:0] min_out;
  logic [1:0] set_state;
  logic       blink_on;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .BLINK_TICKS (BT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_dec      (btn_dec),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .time_count_en(time_count_en),
    .load_en      (load_en),
    .hour_out     (hour_out),
    .min_out      (min_out),
    .set_state    (set_state),
    .blink_on     (blink_on)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_hour, m_min, m_ti, m_td, m_bk;
  bit m_load, m_tcen, m_blink, m_pm, m_pi, m_pd;

  function automatic void m_reset();
    m_state = 0; m_hour = 0; m_min = 0;
    m_ti = 0; m_td = 0; m_bk = 0;
    m_load = 0; m_tcen = 1; m_blink = 0;
    m_pm = 1; m_pi = 1; m_pd = 1;
  endfunction

  function automatic int fstep(int v, int mx, bit up);
    if (up) return (v >= mx) ? 0 : v + 1;
    if (v == 0) return mx;
    if (v > mx) return mx;
    return v - 1;
  endfunction

  // t = ticks held since the press (or since the last clear)
  function automatic bit rep_step(inout int t, input bit lvl,
                                  input bit prev, input bit clr,
                                  input bit tick);
    if (clr || !lvl) begin t = 0; return 1'b0; end
    if (!prev) begin t = 0; return 1'b1; end
    if (!tick) return 1'b0;
    t++;
    return (t == RD) || (t > RD && ((t - RD) % RR) == 0);
  endfunction

  function automatic void m_cycle(bit md, bit in, bit dn, bit tk,
                                  int ch, int cm);
    bit mp, edit, clr, si, sd;
    mp   = md & ~m_pm;
    edit = (m_state == 1) || (m_state == 2);
    clr  = !edit || mp || (in && dn);
    si   = rep_step(m_ti, in, m_pi, clr, tk);
    sd   = rep_step(m_td, dn, m_pd, clr, tk);
    m_pm = md; m_pi = in; m_pd = dn;
    m_load = 0;
    case (m_state)
      0: begin
        m_tcen = 1; m_blink = 0;
        if (mp) begin
          m_state = 1; m_hour = ch; m_min = cm;
          m_tcen = 0; m_blink = 1; m_bk = 0;
        end
      end
      1, 2: begin
        if (mp) begin
          if (m_state == 1) begin
            m_state = 2; m_blink = 1; m_bk = 0;
          end else begin
            m_state = 3; m_load = 1; m_blink = 0;
          end
        end else begin
          if (si || sd) begin
            if (m_state == 1) m_hour = fstep(m_hour, 23, si);
            else m_min = fstep(m_min, 59, si);
          end
          if (tk) m_bk++;
          m_blink = ((m_bk / BT) % 2) == 0;
        end
      end
      default: begin
        m_state = 0; m_tcen = 1;
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s got %0d want %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_state"}, 32'(set_state), m_state);
    chk({tag, "_hour"}, 32'(hour_out), m_hour);
    chk({tag, "_min"}, 32'(min_out), m_min);
    chk({tag, "_load"}, 32'(load_en), int'(m_load));
    chk({tag, "_tcen"}, 32'(time_count_en), int'(m_tcen));
    chk({tag, "_blink"}, 32'(blink_on), int'(m_blink));
  endtask

  task automatic cyc(input bit md, input bit in, input bit dn,
                     input bit tk, input string tag);
    btn_mode = md; btn_inc = in; btn_dec = dn; tick_en = tk;
    @(posedge clk);
    #1;
    m_cycle(md, in, dn, tk, int'(cur_hour), int'(cur_min));
    chk_all(tag);
  endtask

  task automatic press(input bit md, input bit in, input bit dn,
                       input string tag);
    cyc(md, in, dn, 1'b0, tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all(tag);
  endtask

  typedef struct {
    bit md; bit in; bit dn;
    int st; int hr; int mn;
    bit ld; bit tc; bit bl;
  } vec_t;

  vec_t tv[12];

  initial begin
    bit md, in, dn;
    int hl;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b1; btn_dec = 1'b0;
    tick_en = 1'b0; cur_hour = 5'd0; cur_min = 6'd0;

    // Reset with inc held, then release/re-press while running
    #3;
    m_reset();
    chk_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, "held_inc");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "rel_inc");
    press(1'b0, 1'b1, 1'b0, "repress_inc");
    chk("run_hour_untouched", 32'(hour_out), 0);

    // Wrap and simultaneous-event vectors
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 59, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 1, 0, 59, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1, 23, 59, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1, 23, 59, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 2, 23, 59, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 2, 23, 59, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 2, 23, 0, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 2, 23, 0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 2, 23, 0, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 2, 23, 0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 1'b0, 3, 23, 0, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 0, 23, 0, 1'b0, 1'b1, 1'b0};
    cur_hour = 5'd0; cur_min = 6'd59;
    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].md, tv[i].in, tv[i].dn, 1'b0, "tv_model");
      chk($sformatf("tv%0d_state", i), 32'(set_state), tv[i].st);
      chk($sformatf("tv%0d_hour", i), 32'(hour_out), tv[i].hr);
      chk($sformatf("tv%0d_min", i), 32'(min_out), tv[i].mn);
      chk($sformatf("tv%0d_load", i), 32'(load_en), int'(tv[i].ld));
      chk($sformatf("tv%0d_tcen", i), 32'(time_count_en), int'(tv[i].tc));
      chk($sformatf("tv%0d_blink", i), 32'(blink_on), int'(tv[i].bl));
    end

    // 13:45 -> inc x11 -> dec x46 -> commit 00:59
    cur_hour = 5'd13; cur_min = 6'd45;
    press(1'b1, 1'b0, 1'b0, "s2_mode");
    repeat (11) press(1'b0, 1'b1, 1'b0, "s2_inc");
    chk("s2_hour_wrapped", 32'(hour_out), 0);
    press(1'b1, 1'b0, 1'b0, "s2_mode");
    repeat (46) press(1'b0, 1'b0, 1'b1, "s2_dec");
    chk("s2_tcen_edit", 32'(time_count_en), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "s2_commit");
    chk("s2_load_hi", 32'(load_en), 1);
    chk("s2_hour_out", 32'(hour_out), 0);
    chk("s2_min_out", 32'(min_out), 59);
    chk("s2_tcen_commit", 32'(time_count_en), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "s2_after");
    chk("s2_load_lo", 32'(load_en), 0);
    chk("s2_tcen_back", 32'(time_count_en), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "s2_idle");
    chk("s2_load_single", 32'(load_en), 0);

    // Hold inc for 100 ticks in SET_MIN from 10
    cur_hour = 5'd5; cur_min = 6'd10;
    press(1'b1, 1'b0, 1'b0, "s4_mode");
    press(1'b1, 1'b0, 1'b0, "s4_mode");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "s4_press");
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "s4_tick");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "s4_gap");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "s4_rel");
    chk("s4_min_repeat", 32'(min_out), 17);
    press(1'b1, 1'b0, 1'b0, "s4_commit");

    // Reset mid-edit in SET_MIN
    press(1'b1, 1'b0, 1'b0, "s6_mode");
    press(1'b1, 1'b0, 1'b0, "s6_mode");
    chk("s6_in_setmin", 32'(set_state), 2);
    do_reset("s6_rst");
    chk("s6_tcen", 32'(time_count_en), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "s6_idle");
      chk("s6_no_load", 32'(load_en), 0);
      chk("s6_blink_off", 32'(blink_on), 0);
    end

    // Randomized run against the model
    md = 0; in = 0; dn = 0;
    for (int k = 0; k < 4000; k++) begin
      hl = ((k / 1000) % 2 == 1) ? 150 : 5;
      if ($urandom_range(0, (hl == 5) ? 11 : 299) == 0) md = ~md;
      if ($urandom_range(0, hl - 1) == 0) in = ~in;
      if ($urandom_range(0, hl - 1) == 0) dn = ~dn;
      cur_hour = 5'($urandom_range(0, 31));
      cur_min  = 6'($urandom_range(0, 63));
      if (k == 2500) do_reset("rnd_rst");
      cyc(md, in, dn, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
